cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line fills (plus dirty-victim write-back) onto one memory port.
// Readies are one-cycle pulses; under both_access the two fills are released together.
module cache_mem_arbiter #(
  parameter int LINE_BITS = 64,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_miss,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 d_miss,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic                 d_wb,
  input  logic [ADDR_BITS-1:0] d_wb_addr,
  input  logic [LINE_BITS-1:0] d_wb_data,
  input  logic                 both_access,
  output logic                 i_ready,
  output logic                 d_ready,
  output logic [LINE_BITS-1:0] i_fill_data,
  output logic [LINE_BITS-1:0] d_fill_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic [2:0]           dbg_state,
  output logic [1:0]           dbg_done
);

  // Handshake: a miss is a level held until its ready pulse is sampled; the memory side
  // holds mem_req and all mem_* fields stable until the single-cycle mem_ack.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_WB   = 3'd1,
    D_FILL = 3'd2,
    I_FILL = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   i_done_q, i_done_d, d_done_q, d_done_d;
  logic   i_ready_d, d_ready_d;

  always_comb begin
    state_d   = state_q;
    i_done_d  = i_done_q;
    d_done_d  = d_done_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A miss still high during its own ready cycle has already been served.
        if (d_miss && !d_ready)      state_d = d_wb ? D_WB : D_FILL;
        else if (i_miss && !i_ready) state_d = I_FILL;
      end
      D_WB: begin
        if (mem_ack) state_d = D_FILL;
      end
      D_FILL: begin
        if (mem_ack) begin
          if (both_access || i_done_q) begin
            d_done_d = 1'b1;
            state_d  = HOLD;
          end else begin
            d_ready_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      I_FILL: begin
        if (mem_ack) begin
          if (both_access || d_done_q) begin
            i_done_d = 1'b1;
            state_d  = HOLD;
          end else begin
            i_ready_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        if (i_done_q && d_done_q) begin
          i_ready_d = 1'b1;
          d_ready_d = 1'b1;
          i_done_d  = 1'b0;
          d_done_d  = 1'b0;
          state_d   = IDLE;
        end else if (d_done_q && !d_miss) begin
          d_done_d = 1'b0;
          state_d  = IDLE;
        end else if (i_done_q && !i_miss) begin
          i_done_d = 1'b0;
          state_d  = IDLE;
        end else if (d_done_q && i_miss) begin
          state_d = I_FILL;
        end else if (i_done_q && d_miss) begin
          state_d = d_wb ? D_WB : D_FILL;
        end else if (!both_access) begin
          // Hazard controller no longer waits on both: release whatever is done.
          i_ready_d = i_done_q;
          d_ready_d = d_done_q;
          i_done_d  = 1'b0;
          d_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_fill_data <= '0;
      d_fill_data <= '0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      i_ready  <= i_ready_d;
      d_ready  <= d_ready_d;
      // Memory fields are latched only on entry so they stay stable through the transaction.
      if (state_d != state_q) begin
        case (state_d)
          D_WB: begin
            mem_addr  <= {d_wb_addr[ADDR_BITS-1:2], 2'b00};
            mem_wdata <= d_wb_data;
          end
          D_FILL: begin
            mem_addr  <= {d_addr[ADDR_BITS-1:2], 2'b00};
            mem_wdata <= '0;
          end
          I_FILL: begin
            mem_addr  <= {i_addr[ADDR_BITS-1:2], 2'b00};
            mem_wdata <= '0;
          end
          default: ;
        endcase
      end
      if (mem_ack && state_q == D_FILL) d_fill_data <= mem_rdata;
      if (mem_ack && state_q == I_FILL) i_fill_data <= mem_rdata;
    end
  end

  assign mem_req   = (state_q == D_WB) || (state_q == D_FILL) || (state_q == I_FILL);
  assign mem_we    = (state_q == D_WB);
  assign dbg_state = state_q;
  assign dbg_done  = {d_done_q, i_done_q};

endmodule
